prbs7_checker: RTL and testbench
================================

Name: prbs7_checker

Overview:
- Receive-side counterpart of the PRBS7 generator. Takes parallel words from the deserializer/aligner path and self-synchronises a local PRBS7 (x^7+x^6+1) reference.
- Once synchronised, declares lock and counts bit errors, so a serial link BER test can run entirely on-chip.
- Bit convention matches the transmitter: LSB first, so din[0] is the earliest bit of each word.

Parameters:
- WORDWIDTH, 32, word width in bits; legal range 7..32.
- LOCK_WORDS, 4, consecutive clean words required in VERIFY before lock.
- UNLOCK_WORDS, 4, consecutive erroneous words in LOCKED that force a return to HUNT.
- CNT_WIDTH, 16, width of the accumulated error counter.

Ports:
- clk  in  1  word clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- dis  in  1  1 = freeze all state and counters; no words accepted.
- dinValid  in  1  din holds a new word this cycle.
- din  in  WORDWIDTH  received word, LSB = earliest bit.
- clearCount  in  1  synchronous clear of errorCount.
- locked  out  1  local reference synchronised.
- wordErrors  out  6  bit errors in the last checked word.
- errorFlag  out  1  last checked word had at least one error (1-cycle pulse).
- errorCount  out  CNT_WIDTH  saturating sum of wordErrors while locked.

Behaviour:
- Reset (reset=0):
  - state=HUNT, hist=0, gen=0, goodCnt=0, badCnt=0.
  - locked=0, wordErrors=0, errorFlag=0, errorCount=0.
- A word is accepted when dinValid=1 and dis=0. With dis=1, every register holds its value and errorFlag=0.
- All outputs are registered. Results for an accepted word appear on the next clk edge (1-cycle latency).
- Stream relation: bit n = bit(n-6) XOR bit(n-7). Bits are indexed across word boundaries.
- hist[6:0] holds the last 7 received bits, hist[6] most recent. It updates from din[W-1:W-7] on every accepted word, in every state.
- Feed-forward prediction (HUNT/VERIFY):
  - e[i] = x[i-6] XOR x[i-7], where x = {din, hist} viewed as one LSB-first stream.
  - Mismatch vector = din XOR e.
- Local prediction (LOCKED):
  - p[i] is generated from gen, the last 7 reference bits, and is not influenced by din.
  - gen advances by WORDWIDTH bits per accepted word.
  - Mismatch vector = din XOR p.
- wordErrors = popcount(mismatch). It is updated on every accepted word in VERIFY and LOCKED, and forced to 0 in HUNT.
- errorFlag = (wordErrors != 0) for that word.
- FSM:
  - HUNT: the first accepted word only fills hist, then -> VERIFY with goodCnt=0.
  - VERIFY:
    - Clean word: goodCnt++. When goodCnt reaches LOCK_WORDS -> LOCKED, with gen loaded from din[W-1:W-7] of that word and badCnt=0.
    - Erroneous word: -> HUNT.
  - LOCKED:
    - Erroneous word: badCnt++. When it reaches UNLOCK_WORDS -> HUNT, and locked clears on the same edge.
    - Clean word: badCnt=0.
- locked = (state == LOCKED), registered.
- errorCount:
  - Adds wordErrors only for words checked in LOCKED, including the word that triggers unlock.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - Holds its value across loss of lock. Only reset or clearCount zero it.
- clearCount=1 on an accepting cycle: errorCount <= that word's error contribution. Clear applies first, then the add.
- reset deasserted mid-stream: the block restarts in HUNT; no partial state is retained.
- Timing: an error-free stream reaches lock on the edge after the (1+LOCK_WORDS)-th accepted word.

Optional Feature:
- Macro PRBS7_CHK_ERRMAP_EN.
- Defined: extra output errMap[WORDWIDTH-1:0] gives the registered mismatch vector, with the same timing as wordErrors. It is 0 in HUNT and 0 on reset.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Clean lock: PRBS7 seed 7'h7F, WORDWIDTH=32, dinValid=1 every cycle. Expect locked=1 on the edge after word 5, wordErrors=0 throughout, errorCount=0 after 1000 words.
- Single-bit error: locked, flip din[13] of one word. Expect wordErrors=1 and errorFlag pulse for exactly one cycle, errorCount=1, locked stays 1, and the next word reports 0.
- Loss of lock: locked, invert 4 consecutive words. Expect wordErrors=32 each, errorCount=128, locked=0 after the 4th; clean data then relocks after 5 words with errorCount still 128.
- Saturation/clear: CNT_WIDTH=8, inverted words while locked. Expect errorCount to stick at 255. Assert clearCount on a word with 3 flipped bits; expect errorCount=3.
- dis/dinValid gaps: random dinValid=0 and dis=1 cycles inside a clean stream. Expect state, counters and lock unchanged, and no errors.
- Async reset: pull reset low mid-LOCKED for a fraction of a cycle. Expect all outputs 0 immediately; after release, relock takes 5 words.

Source files
------------

// File: rtl/prbs7_checker.sv
// prbs7_checker
// Receive-side PRBS7 (x^7 + x^6 + 1) checker. It self-synchronises a local
// reference to the incoming parallel word stream, declares lock, and then
// counts bit errors so a link BER test can run on-chip.
// Bit order is LSB first: din[0] is the earliest bit of each word.
//
// Ports:
//   clk         word clock, rising edge
//   reset       asynchronous active-low reset
//   dis         1 = freeze all state and counters (no words accepted)
//   dinValid    din holds a new word this cycle
//   din         received word, LSB = earliest bit
//   clearCount  synchronous clear of errorCount (clear first, then add)
//   locked      local reference synchronised (registered)
//   wordErrors  bit errors in the last checked word
//   errorFlag   1-cycle pulse: last checked word had at least one error
//   errorCount  saturating sum of wordErrors over words checked while locked
//   errMap      registered mismatch vector (only with PRBS7_CHK_ERRMAP_EN)
//   state_dbg   current FSM state (HUNT=0, VERIFY=1, LOCKED=2)
//
// Optional feature macro: PRBS7_CHK_ERRMAP_EN adds the errMap output.
//
// Handshake: a word is consumed on a rising edge where dinValid=1 and dis=0.
// There is no back-pressure; the checker accepts every offered word.
module prbs7_checker #(
  parameter int WORDWIDTH    = 32,
  parameter int LOCK_WORDS   = 4,
  parameter int UNLOCK_WORDS = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dis,
  input  logic                 dinValid,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 clearCount,
  output logic                 locked,
  output logic [5:0]           wordErrors,
  output logic                 errorFlag,
  output logic [CNT_WIDTH-1:0] errorCount,
`ifdef PRBS7_CHK_ERRMAP_EN
  output logic [WORDWIDTH-1:0] errMap,
`endif
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam int GW = $clog2(LOCK_WORDS + 1);
  localparam int BW = $clog2(UNLOCK_WORDS + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_WORDS - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_WORDS - 1);
  // Sum width wide enough for the counter plus a full word of errors.
  localparam int SW = ((CNT_WIDTH > 6) ? CNT_WIDTH : 6) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

  state_t         state;
  logic [6:0]     hist;      // last 7 received bits, hist[6] most recent
  logic [6:0]     gen;       // last 7 local reference bits, gen[6] most recent
  logic [GW-1:0]  good_cnt;
  logic [BW-1:0]  bad_cnt;

  logic [WORDWIDTH-1:0] mismatch;
  logic [WORDWIDTH-1:0] ref_pred;
  logic [5:0]           wc;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Feed-forward prediction: each bit is predicted from the received stream
  // itself, x = {din, hist}, so bit i of din sees bits i-6 and i-7.
  function automatic logic [WORDWIDTH-1:0] ff_predict(input logic [WORDWIDTH+6:0] x);
    logic [WORDWIDTH-1:0] e;
    e = '0;
    for (int i = 0; i < WORDWIDTH; i++) e[i] = x[i+1] ^ x[i];
    return e;
  endfunction

  // Free-running reference: extend gen by WORDWIDTH bits using only its own
  // history, so received errors cannot disturb it.
  function automatic logic [WORDWIDTH-1:0] ref_predict(input logic [6:0] g);
    logic [WORDWIDTH+6:0] y;
    y = {{WORDWIDTH{1'b0}}, g};
    for (int i = 0; i < WORDWIDTH; i++) y[i+7] = y[i+1] ^ y[i];
    return y[WORDWIDTH+6:7];
  endfunction

  function automatic logic [5:0] popcount(input logic [WORDWIDTH-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < WORDWIDTH; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  always_comb begin
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [SW-1:0]        cnt_sum;
    ref_pred = ref_predict(gen);
    if (state == LOCKED) mismatch = din ^ ref_pred;
    else                 mismatch = din ^ ff_predict({din, hist});
    wc       = popcount(mismatch);
    cnt_base = clearCount ? '0 : errorCount;
    cnt_sum  = SW'(cnt_base) + SW'(wc);
    cnt_next = (cnt_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      hist       <= '0;
      gen        <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      locked     <= 1'b0;
      wordErrors <= '0;
      errorFlag  <= 1'b0;
      errorCount <= '0;
`ifdef PRBS7_CHK_ERRMAP_EN
      errMap     <= '0;
`endif
    end else begin
      errorFlag <= 1'b0;
      if (!dis) begin
        if (clearCount) errorCount <= '0;
        if (dinValid) begin
          hist <= din[WORDWIDTH-1 -: 7];
          case (state)
            HUNT: begin
              // First word only primes hist.
              state      <= VERIFY;
              good_cnt   <= '0;
              wordErrors <= '0;
`ifdef PRBS7_CHK_ERRMAP_EN
              errMap     <= '0;
`endif
            end
            VERIFY: begin
              wordErrors <= wc;
              errorFlag  <= (wc != 6'd0);
`ifdef PRBS7_CHK_ERRMAP_EN
              errMap     <= mismatch;
`endif
              if (wc == 6'd0) begin
                good_cnt <= good_cnt + GW'(1);
                if (good_cnt == GOOD_LAST) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  gen     <= din[WORDWIDTH-1 -: 7];
                  bad_cnt <= '0;
                end
              end else begin
                state <= HUNT;
              end
            end
            LOCKED: begin
              wordErrors <= wc;
              errorFlag  <= (wc != 6'd0);
`ifdef PRBS7_CHK_ERRMAP_EN
              errMap     <= mismatch;
`endif
              errorCount <= cnt_next;
              gen        <= ref_pred[WORDWIDTH-1 -: 7];
              if (wc != 6'd0) begin
                if (bad_cnt == BAD_LAST) begin
                  state   <= HUNT;
                  locked  <= 1'b0;
                  bad_cnt <= '0;
                end else begin
                  bad_cnt <= bad_cnt + BW'(1);
                end
              end else begin
                bad_cnt <= '0;
              end
            end
            default: begin
              state  <= HUNT;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker (WORDWIDTH=32, CNT_WIDTH=8). A bit-level reference
// model keeps the received and reference streams as bit queues and applies
// the PRBS7 recurrence directly; outputs are compared after every edge.
module tb_prbs7_checker;

  localparam int W       = 32;
  localparam int CW      = 8;
  localparam int LOCK_N  = 4;
  localparam int UNLK_N  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          dis;
  logic          dinValid;
  logic [W-1:0]  din;
  logic          clearCount;
  logic          locked;
  logic [5:0]    wordErrors;
  logic          errorFlag;
  logic [CW-1:0] errorCount;
  logic [1:0]    state_dbg;
`ifdef PRBS7_CHK_ERRMAP_EN
  logic [W-1:0]  errMap;
`endif

  always #5 clk = ~clk;

  prbs7_checker #(
    .WORDWIDTH(W), .LOCK_WORDS(LOCK_N), .UNLOCK_WORDS(UNLK_N), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dis(dis),
    .dinValid(dinValid),
    .din(din),
    .clearCount(clearCount),
    .locked(locked),
    .wordErrors(wordErrors),
    .errorFlag(errorFlag),
    .errorCount(errorCount),
`ifdef PRBS7_CHK_ERRMAP_EN
    .errMap(errMap),
`endif
    .state_dbg(state_dbg)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- transmitter stream ----------------
  bit tx_q[$];

  task automatic next_tx(output logic [W-1:0] w);
    bit b;
    for (int i = 0; i < W; i++) begin
      b = tx_q[tx_q.size()-6] ^ tx_q[tx_q.size()-7];
      tx_q.push_back(b);
      w[i] = b;
    end
    while (tx_q.size() > 16) void'(tx_q.pop_front());
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_HUNT, M_VERIFY, M_LOCKED} mstate_t;
  mstate_t     m_state;
  int          m_good, m_bad, m_we, m_cnt;
  logic        m_flag, m_locked;
  logic [W-1:0] m_map;
  bit          rx_q[$];
  bit          ref_q[$];

  task automatic model_reset();
    m_state = M_HUNT; m_good = 0; m_bad = 0; m_we = 0; m_cnt = 0;
    m_flag = 1'b0; m_locked = 1'b0; m_map = '0;
    rx_q.delete(); ref_q.delete();
    for (int k = 0; k < 7; k++) begin rx_q.push_back(1'b0); ref_q.push_back(1'b0); end
  endtask

  task automatic model_step(input logic v, input logic d, input logic [W-1:0] w, input logic clr);
    bit pb;
    int errs;
    logic [W-1:0] mis;
    m_flag = 1'b0;
    if (d) return;
    if (clr) m_cnt = 0;
    if (!v) return;
    errs = 0; mis = '0;
    for (int i = 0; i < W; i++) begin
      if (m_state == M_LOCKED) begin
        pb = ref_q[ref_q.size()-6] ^ ref_q[ref_q.size()-7];
        ref_q.push_back(pb);
      end else begin
        pb = rx_q[rx_q.size()-6] ^ rx_q[rx_q.size()-7];
      end
      rx_q.push_back(w[i]);
      if (m_state != M_HUNT && pb != w[i]) begin mis[i] = 1'b1; errs++; end
    end
    while (rx_q.size() > 16) void'(rx_q.pop_front());
    while (ref_q.size() > 16) void'(ref_q.pop_front());
    case (m_state)
      M_HUNT: begin
        m_we = 0; m_map = '0; m_state = M_VERIFY; m_good = 0;
      end
      M_VERIFY: begin
        m_we = errs; m_map = mis; m_flag = (errs != 0);
        if (errs == 0) begin
          m_good++;
          if (m_good == LOCK_N) begin
            m_state = M_LOCKED; m_bad = 0;
            ref_q.delete();
            for (int k = 7; k >= 1; k--) ref_q.push_back(rx_q[rx_q.size()-k]);
          end
        end else begin
          m_state = M_HUNT;
        end
      end
      default: begin
        m_we = errs; m_map = mis; m_flag = (errs != 0);
        m_cnt = m_cnt + errs;
        if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
        if (errs != 0) begin
          m_bad++;
          if (m_bad == UNLK_N) begin m_state = M_HUNT; m_bad = 0; end
        end else begin
          m_bad = 0;
        end
      end
    endcase
    m_locked = (m_state == M_LOCKED);
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] w, input logic v, input logic d, input logic clr, input string tag);
    @(negedge clk);
    din = w; dinValid = v; dis = d; clearCount = clr;
    model_step(v, d, w, clr);
    @(posedge clk);
    #1;
    check_eq({tag, ".locked"}, 32'(locked), 32'(m_locked));
    check_eq({tag, ".wordErrors"}, 32'(wordErrors), 32'(m_we));
    check_eq({tag, ".errorFlag"}, 32'(errorFlag), 32'(m_flag));
    check_eq({tag, ".errorCount"}, 32'(errorCount), 32'(m_cnt));
`ifdef PRBS7_CHK_ERRMAP_EN
    check_eq({tag, ".errMap"}, errMap, m_map);
`endif
    dinValid = 1'b0; dis = 1'b0; clearCount = 1'b0;
  endtask

  task automatic send_clean(input string tag);
    logic [W-1:0] w;
    next_tx(w);
    send(w, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic send_mod(input logic [W-1:0] flip, input logic clr, input string tag);
    logic [W-1:0] w;
    next_tx(w);
    send(w ^ flip, 1'b1, 1'b0, clr, tag);
  endtask

  // ---------------- stimulus + scoreboard checks ----------------
  initial begin
    logic [W-1:0] w;
    int r;
    reset = 1'b0; dis = 1'b0; dinValid = 1'b0; din = '0; clearCount = 1'b0;
    for (int k = 0; k < 7; k++) tx_q.push_back(1'b1);  // seed 7'h7F
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.locked", 32'(locked), 32'd0);
    check_eq("rst.wordErrors", 32'(wordErrors), 32'd0);
    check_eq("rst.errorFlag", 32'(errorFlag), 32'd0);
    check_eq("rst.errorCount", 32'(errorCount), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Clean lock: lock on the edge after the 5th word.
    for (int n = 1; n <= 5; n++) begin
      send_clean("lock");
      if (n == 4) check_eq("lock.after4", 32'(locked), 32'd0);
    end
    check_eq("lock.after5", 32'(locked), 32'd1);
    for (int n = 0; n < 995; n++) send_clean("clean");
    check_eq("clean.count", 32'(errorCount), 32'd0);

    // Single-bit error on din[13].
    send_mod(32'h0000_2000, 1'b0, "bit13");
    check_eq("bit13.we", 32'(wordErrors), 32'd1);
    check_eq("bit13.flag", 32'(errorFlag), 32'd1);
    check_eq("bit13.cnt", 32'(errorCount), 32'd1);
    check_eq("bit13.locked", 32'(locked), 32'd1);
    send_clean("after13");
    check_eq("after13.we", 32'(wordErrors), 32'd0);
    check_eq("after13.flag", 32'(errorFlag), 32'd0);

    // Loss of lock: clear, then 4 inverted words, then relock.
    send_mod('0, 1'b1, "clr0");
    for (int n = 1; n <= 4; n++) send_mod('1, 1'b0, "inv");
    check_eq("unlock.we", 32'(wordErrors), 32'd32);
    check_eq("unlock.cnt", 32'(errorCount), 32'd128);
    check_eq("unlock.locked", 32'(locked), 32'd0);
    for (int n = 1; n <= 5; n++) begin
      send_clean("relock");
      if (n == 4) check_eq("relock.after4", 32'(locked), 32'd0);
    end
    check_eq("relock.after5", 32'(locked), 32'd1);
    check_eq("relock.cnt", 32'(errorCount), 32'd128);

    // Saturation at 255, then clear combined with a 3-bit-error word.
    for (int n = 0; n < 3; n++) send_mod('1, 1'b0, "sat_a");
    send_clean("sat_gap");
    for (int n = 0; n < 3; n++) send_mod('1, 1'b0, "sat_b");
    check_eq("sat.cnt", 32'(errorCount), 32'd255);
    send_clean("sat_gap2");
    check_eq("sat.hold", 32'(errorCount), 32'd255);
    send_mod(32'h8004_0001, 1'b1, "clr3");
    check_eq("clr3.cnt", 32'(errorCount), 32'd3);
    check_eq("clr3.locked", 32'(locked), 32'd1);

    // dinValid gaps and dis freezes inside a clean stream.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      w = $urandom();
      if (r < 2)       send(w, 1'b0, 1'b0, 1'b0, "gap");
      else if (r == 2) send(w, 1'b1, 1'b1, 1'b0, "dis");
      else             send_clean("gapclean");
    end
    check_eq("gap.locked", 32'(locked), 32'd1);
    check_eq("gap.cnt", 32'(errorCount), 32'd3);

    // Short asynchronous reset pulse while locked.
    #1;
    reset = 1'b0;
    #1;
    check_eq("arst.locked", 32'(locked), 32'd0);
    check_eq("arst.cnt", 32'(errorCount), 32'd0);
    check_eq("arst.flag", 32'(errorFlag), 32'd0);
    check_eq("arst.we", 32'(wordErrors), 32'd0);
    #1;
    reset = 1'b1;
    model_reset();
    for (int n = 1; n <= 5; n++) begin
      send_clean("arelock");
      if (n == 4) check_eq("arelock.after4", 32'(locked), 32'd0);
    end
    check_eq("arelock.after5", 32'(locked), 32'd1);

    // Random error injection with occasional clears and gaps.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      w = '0;
      if (r < 3) w[$urandom_range(0, W-1)] = 1'b1;
      if (r == 3) w = $urandom();
      if (r == 4) send($urandom(), 1'b0, 1'b0, 1'b0, "rgap");
      else send_mod(w, ($urandom_range(0, 15) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
